// File: rtl/uart_tx_sched_if.sv
// Bundle of the requester-side and transmitter-side signals of uart_tx_sched.
//   req_valid   [N]    requester i has a byte pending
//   req_data    [8N]   byte of requester i at [8*i+7:8*i]
//   req_ready   [N]    one-cycle accept pulse toward requester i
//   tx_start           one-cycle launch pulse to the UART transmitter
//   tx_data     [8]    byte being transmitted, held until the frame completes
//   tx_busy            transmitter is shifting a frame
//   grant_id    [GW]   index of the current/last granted requester
//   active             scheduler is not idle
//   err_timeout        sticky: transmitter never went busy after a launch
// Modports: master = scheduler side, slave = requesters + transmitter side.
interface uart_tx_sched_if #(
  parameter int N  = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [GW-1:0]  grant_id;
  logic           active;
  logic           err_timeout;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, active, err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between N requesters.
// A pending byte is granted starting the search at the round-robin pointer, launched
// with a one-cycle tx_start, then the transmitter busy flag is tracked to the end of
// the frame, followed by an optional idle gap of GAP cycles.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   uart_tx_sched_if.master (requester handshake + transmitter control)
module uart_tx_sched #(
  parameter int N        = 4,
  parameter int GAP      = 0,
  parameter int START_TO = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_sched_if.master     bus
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t        state_reg;
  logic [GW-1:0] ptr_reg;
  logic [31:0]   cnt_reg;
  logic [N-1:0]  req_ready_reg;
  logic          tx_start_reg;
  logic [7:0]    tx_data_reg;
  logic [GW-1:0] grant_id_reg;
  logic          active_reg;
  logic          err_timeout_reg;

  // Per-requester byte view of the flat data bus.
  logic [7:0] req_byte [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_bytes
    assign req_byte[gi] = bus.req_data[8*gi +: 8];
  end

  // Winner search: first valid bit scanning ptr, ptr+1, ... wrapping modulo N.
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] win_next_ptr;
  int            scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr_reg) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(scan_idx);
      end
    end
    win_next_ptr = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      req_ready_reg   <= '0;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= '0;
      grant_id_reg    <= '0;
      active_reg      <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      // Accept and launch are single-cycle pulses.
      req_ready_reg <= '0;
      tx_start_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (win_found) begin
            req_ready_reg <= N'(1) << win_idx;
            tx_start_reg  <= 1'b1;
            tx_data_reg   <= req_byte[win_idx];
            grant_id_reg  <= win_idx;
            active_reg    <= 1'b1;
            ptr_reg       <= win_next_ptr;
            cnt_reg       <= '0;
            state_reg     <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_reg <= S_WAIT_DONE;
          end else if (cnt_reg == 32'(START_TO - 1)) begin
            // Transmitter never picked the byte up; drop it and move on.
            err_timeout_reg <= 1'b1;
            cnt_reg         <= '0;
            if (GAP > 0) begin
              state_reg <= S_GAP;
            end else begin
              state_reg  <= S_IDLE;
              active_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            cnt_reg <= '0;
            if (GAP > 0) begin
              state_reg <= S_GAP;
            end else begin
              state_reg  <= S_IDLE;
              active_reg <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (cnt_reg == 32'(GAP - 1)) begin
            cnt_reg    <= '0;
            state_reg  <= S_IDLE;
            active_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_reg;
  assign bus.tx_start    = tx_start_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.grant_id    = grant_id_reg;
  assign bus.active      = active_reg;
  assign bus.err_timeout = err_timeout_reg;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: two instances, one with GAP=0 and one with GAP=5,
// both N=4, START_TO=16. The transmitter busy flag is driven by hand per step.
module tb_uart_tx_sched;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_tx_sched_if #(.N(4)) if0 ();
  uart_tx_sched_if #(.N(4)) if5 ();

  uart_tx_sched #(.N(4), .GAP(0), .START_TO(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  uart_tx_sched #(.N(4), .GAP(5), .START_TO(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  int exp_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if0.req_valid = '0; if0.req_data = '0; if0.tx_busy = 1'b0;
    if5.req_valid = '0; if5.req_data = '0; if5.tx_busy = 1'b0;

    // 1: reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx_start", {31'd0, if0.tx_start}, 32'd0);
    end
    check("rst_req_ready", {28'd0, if0.req_ready}, 32'd0);
    check("rst_tx_data", {24'd0, if0.tx_data}, 32'd0);
    check("rst_grant_id", {30'd0, if0.grant_id}, 32'd0);
    check("rst_active", {31'd0, if0.active}, 32'd0);
    check("rst_err", {31'd0, if0.err_timeout}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_no_start", {31'd0, if0.tx_start}, 32'd0);

    // 2: single request from requester 2
    if0.req_data  = {8'h33, 8'h41, 8'h22, 8'h11};
    if0.req_valid = 4'b0100;
    tick();
    check("single_start", {31'd0, if0.tx_start}, 32'd1);
    check("single_data", {24'd0, if0.tx_data}, 32'h41);
    check("single_grant", {30'd0, if0.grant_id}, 32'd2);
    check("single_ready", {28'd0, if0.req_ready}, 32'b0100);
    check("single_active", {31'd0, if0.active}, 32'd1);
    if0.req_valid = '0;
    if0.req_data[23:16] = 8'h55;
    if0.tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("single_busy_start", {31'd0, if0.tx_start}, 32'd0);
      check("single_busy_ready", {28'd0, if0.req_ready}, 32'd0);
    end
    check("single_data_held", {24'd0, if0.tx_data}, 32'h41);
    if0.tx_busy = 1'b0;
    tick();
    check("single_idle_active", {31'd0, if0.active}, 32'd0);
    check("single_grant_kept", {30'd0, if0.grant_id}, 32'd2);

    // 3: fairness from a fresh pointer, all four valid continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if0.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    if0.req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("fair_start", {31'd0, if0.tx_start}, 32'd1);
      check("fair_grant", {30'd0, if0.grant_id}, 32'(exp_order[i]));
      check("fair_data", {24'd0, if0.tx_data}, 32'h0A0 + 32'(exp_order[i]));
      check("fair_ready", {28'd0, if0.req_ready}, 32'd1 << exp_order[i]);
      if (i == 5) if0.req_valid = '0;
      if0.tx_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("fair_busy_start", {31'd0, if0.tx_start}, 32'd0);
        check("fair_busy_ready", {28'd0, if0.req_ready}, 32'd0);
      end
      if0.tx_busy = 1'b0;
      tick();
      check("fair_idle", {31'd0, if0.active}, 32'd0);
      if (i < 5) tick();
    end

    // 4: GAP=5 instance, requesters 0 and 1
    if5.req_data  = {8'h00, 8'h00, 8'hB1, 8'hB0};
    if5.req_valid = 4'b0011;
    tick();
    check("gap_start0", {31'd0, if5.tx_start}, 32'd1);
    check("gap_grant0", {30'd0, if5.grant_id}, 32'd0);
    if5.tx_busy = 1'b1;
    tick();
    tick();
    if5.tx_busy = 1'b0;
    tick();
    check("gap_enter_active", {31'd0, if5.active}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gap_hold_active", {31'd0, if5.active}, 32'd1);
      check("gap_hold_start", {31'd0, if5.tx_start}, 32'd0);
    end
    tick();
    check("gap_idle", {31'd0, if5.active}, 32'd0);
    check("gap_idle_start", {31'd0, if5.tx_start}, 32'd0);
    tick();
    check("gap_start1", {31'd0, if5.tx_start}, 32'd1);
    check("gap_grant1", {30'd0, if5.grant_id}, 32'd1);
    check("gap_data1", {24'd0, if5.tx_data}, 32'hB1);
    if5.req_valid = '0;

    // 5: timeout on the GAP=0 instance (pointer now at 2)
    if0.req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    if0.req_valid = 4'b0100;
    tick();
    check("to_start", {31'd0, if0.tx_start}, 32'd1);
    check("to_grant", {30'd0, if0.grant_id}, 32'd2);
    if0.req_valid = '0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check("to_err_low", {31'd0, if0.err_timeout}, 32'd0);
    end
    tick();
    check("to_err_rise", {31'd0, if0.err_timeout}, 32'd1);
    check("to_idle", {31'd0, if0.active}, 32'd0);
    if0.req_valid = 4'b1000;
    tick();
    check("to_next_start", {31'd0, if0.tx_start}, 32'd1);
    check("to_next_grant", {30'd0, if0.grant_id}, 32'd3);
    check("to_next_data", {24'd0, if0.tx_data}, 32'hC3);
    if0.req_valid = '0;
    if0.tx_busy = 1'b1;
    tick();
    if0.tx_busy = 1'b0;
    tick();
    check("to_err_sticky", {31'd0, if0.err_timeout}, 32'd1);

    // 6: reset while a frame is in flight
    if0.req_valid = 4'b0010;
    tick();
    check("mid_grant", {30'd0, if0.grant_id}, 32'd1);
    if0.req_valid = '0;
    if0.tx_busy = 1'b1;
    tick();
    tick();
    check("mid_active", {31'd0, if0.active}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_active", {31'd0, if0.active}, 32'd0);
    check("mid_rst_err", {31'd0, if0.err_timeout}, 32'd0);
    check("mid_rst_grant", {30'd0, if0.grant_id}, 32'd0);
    rst = 1'b0;
    if0.tx_busy = 1'b0;
    if0.req_valid = 4'b1111;
    tick();
    check("mid_after_start", {31'd0, if0.tx_start}, 32'd1);
    check("mid_after_grant", {30'd0, if0.grant_id}, 32'd0);
    check("mid_after_ready", {28'd0, if0.req_ready}, 32'b0001);
    if0.req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
